register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 186 ++++++++++++++++++
 tb/tb_register_file.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : WIDTH x DEPTH register file with one write port, two registered
//             read ports (1-cycle latency) and a one-entry-per-cycle clear
//             sweep. Writes that cannot be performed are reported on wr_drop.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      clock, rising edge
//    rst_n      in   1      asynchronous active-low reset
//    wr_en      in   1      write request
//    wr_addr    in   AW     write index
//    wr_data    in   WIDTH  write data
//    rd_addr_a  in   AW     read index, port A
//    rd_addr_b  in   AW     read index, port B
//    rd_data_a  out  WIDTH  registered read data, port A
//    rd_data_b  out  WIDTH  registered read data, port B
//    clr        in   1      clear request pulse
//    busy       out  1      clear sweep in progress
//    wr_drop    out  1      pulse: write of the previous cycle was discarded
// ----------------------------------------------------------------------------
//  Build option
//    REGISTER_FILE_BYPASS_EN  when defined, a read whose address matches a
//                             write accepted at the same edge returns the new
//                             write data instead of the old entry contents.
// ============================================================================
module register_file #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr,
    output logic             busy,
    output logic             wr_drop
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             wr_drop_q;

    logic w_busy;
    logic w_wr_in_range;
    logic w_wr_accept;
    logic w_wr_drop;
    logic w_clr_start;
    logic w_rd_a_in_range;
    logic w_rd_b_in_range;

    assign w_busy          = (state_q == ST_CLEAR);
    assign w_wr_in_range   = ({1'b0, wr_addr} < c_depth);
    // A clear request takes priority over a same-cycle write.
    assign w_wr_accept     = wr_en & ~w_busy & ~clr & w_wr_in_range;
    assign w_wr_drop       = wr_en & ~w_wr_accept;
    // clr during an active sweep is ignored; the sweep is never restarted.
    assign w_clr_start     = clr & ~w_busy;
    assign w_rd_a_in_range = ({1'b0, rd_addr_a} < c_depth);
    assign w_rd_b_in_range = ({1'b0, rd_addr_b} < c_depth);

    // ------------------------------------------------------------------------
    // Clear-sweep controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == c_last_idx) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage. The sweep and an accepted write are mutually exclusive because
    // writes are only accepted while not busy.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (w_busy) begin
            mem_d[cnt_q] = '0;
        end else if (w_wr_accept) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports. Out-of-range indices (possible when DEPTH is not a power of
    // two) return zero rather than touching a non-existent entry.
    // ------------------------------------------------------------------------
    always_comb begin
        rd_data_a_d = '0;
        rd_data_b_d = '0;
        if (w_rd_a_in_range) begin
            rd_data_a_d = mem_q[rd_addr_a];
`ifdef REGISTER_FILE_BYPASS_EN
            if (w_wr_accept && (wr_addr == rd_addr_a)) begin
                rd_data_a_d = wr_data;
            end
`endif
        end
        if (w_rd_b_in_range) begin
            rd_data_b_d = mem_q[rd_addr_b];
`ifdef REGISTER_FILE_BYPASS_EN
            if (w_wr_accept && (wr_addr == rd_addr_b)) begin
                rd_data_b_d = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            wr_drop_q   <= 1'b0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            wr_drop_q   <= w_wr_drop;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign busy      = w_busy;
    assign wr_drop   = wr_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : self-checking bench for register_file (WIDTH=8, DEPTH=8 main
//             instance plus a DEPTH=6 instance for out-of-range indices).
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    // Main instance, DEPTH = 8
    logic       we, clr;
    logic [2:0] wa, ra, rb;
    logic [7:0] wd;
    logic [7:0] rda, rdb;
    logic       busy, drop;

    // Second instance, DEPTH = 6
    logic       d6_we, d6_clr;
    logic [2:0] d6_wa, d6_ra, d6_rb;
    logic [7:0] d6_wd;
    logic [7:0] d6_rda, d6_rdb;
    logic       d6_busy, d6_drop;

    int tests;
    int fails;

    register_file #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (we),
        .wr_addr   (wa),
        .wr_data   (wd),
        .rd_addr_a (ra),
        .rd_addr_b (rb),
        .rd_data_a (rda),
        .rd_data_b (rdb),
        .clr       (clr),
        .busy      (busy),
        .wr_drop   (drop)
    );

    register_file #(.WIDTH(8), .DEPTH(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (d6_we),
        .wr_addr   (d6_wa),
        .wr_data   (d6_wd),
        .rd_addr_a (d6_ra),
        .rd_addr_b (d6_rb),
        .rd_data_a (d6_rda),
        .rd_data_b (d6_rdb),
        .clr       (d6_clr),
        .busy      (d6_busy),
        .wr_drop   (d6_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Reference model: plain storage array plus "sweep position" bookkeeping.
    // ------------------------------------------------------------------------
    logic [7:0] m_mem [8];
    bit         m_sweep;
    int         m_idx;
    logic [7:0] e_a, e_b;
    bit         e_busy, e_drop;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_sweep = 1'b0;
        m_idx   = 0;
        e_a     = 8'h00;
        e_b     = 8'h00;
        e_busy  = 1'b0;
        e_drop  = 1'b0;
    endtask

    // Applies one rising edge worth of behaviour to the model.
    task automatic model_edge();
        bit acc;
        acc = we && !m_sweep && !clr;
        e_a = (BYP && acc && (wa == ra)) ? wd : m_mem[ra];
        e_b = (BYP && acc && (wa == rb)) ? wd : m_mem[rb];
        e_drop = we && !acc;
        if (m_sweep) begin
            m_mem[m_idx] = 8'h00;
            m_idx++;
            if (m_idx == 8) m_sweep = 1'b0;
        end else if (clr) begin
            m_sweep = 1'b1;
            m_idx   = 0;
        end
        if (acc) m_mem[wa] = wd;
        e_busy = m_sweep;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge,
    // then compare every output against the model at the next falling edge.
    task automatic tick(input bit i_we, input int i_wa, input int i_wd,
                        input int i_ra, input int i_rb, input bit i_clr);
        logic [31:0] v_wa, v_wd, v_ra, v_rb;
        v_wa = i_wa; v_wd = i_wd; v_ra = i_ra; v_rb = i_rb;
        we  = i_we;
        wa  = v_wa[2:0];
        wd  = v_wd[7:0];
        ra  = v_ra[2:0];
        rb  = v_rb[2:0];
        clr = i_clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_rd_data_a", rda, e_a);
        chk("model_rd_data_b", rdb, e_b);
        chk("model_busy", busy, e_busy);
        chk("model_wr_drop", drop, e_drop);
    endtask

    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       clr;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    vec_t vt [7];

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        we = 0; wa = 0; wd = 0; ra = 0; rb = 0; clr = 0;
        d6_we = 0; d6_wa = 0; d6_wd = 0; d6_ra = 0; d6_rb = 0; d6_clr = 0;
        model_reset();

        // Directed vectors from a freshly reset array.
        vt[0] = '{1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0, 8'h00, 8'h00};
        vt[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0, 8'hA5, 8'h00};
        vt[2] = '{1'b1, 3'd5, 8'h11, 3'd5, 3'd3, 1'b0, (BYP ? 8'h11 : 8'h00), 8'hA5};
        vt[3] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 1'b0, (BYP ? 8'h3C : 8'h11), (BYP ? 8'h3C : 8'h11)};
        vt[4] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0, 8'h3C, 8'hA5};
        vt[5] = '{1'b1, 3'd0, 8'h77, 3'd7, 3'd0, 1'b0, 8'h00, (BYP ? 8'h77 : 8'h00)};
        vt[6] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b0, 8'h77, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_rd_data_a", rda, 8'h00);
        chk("reset_rd_data_b", rdb, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wr_drop", drop, 1'b0);
        chk("reset_d6_busy", d6_busy, 1'b0);
        rst_n = 1'b1;

        // Table: first edge after reset release already carries a write.
        for (int i = 0; i < 7; i++) begin
            tick(vt[i].we, int'(vt[i].wa), int'(vt[i].wd), int'(vt[i].ra), int'(vt[i].rb), vt[i].clr);
            chk($sformatf("vec%0d_rd_data_a", i), rda, vt[i].ea);
            chk($sformatf("vec%0d_rd_data_b", i), rdb, vt[i].eb);
        end

        // Fill, sweep, count busy cycles, read back.
        for (int i = 0; i < 8; i++) tick(1'b1, i, 'h10 + i, 0, 0, 1'b0);
        tick(1'b0, 0, 0, 7, 0, 1'b1);
        chk("clr_busy_rises", busy, 1'b1);
        n = busy ? 1 : 0;
        tick(1'b0, 0, 0, 7, 0, 1'b0);
        chk("mid_sweep_addr7", rda, 8'h17);
        if (busy) n++;
        for (int k = 0; k < 20 && busy; k++) begin
            tick(1'b0, 0, 0, k % 8, 7, 1'b0);
            if (busy) n++;
        end
        chk("sweep_busy_cycles", n, 8);
        for (int a = 0; a < 8; a++) begin
            tick(1'b0, 0, 0, a, 7 - a, 1'b0);
            chk($sformatf("after_sweep_addr%0d", a), rda, 8'h00);
        end

        // Discarded writes: with clr, during busy; clr during busy ignored.
        tick(1'b1, 2, 'h55, 2, 0, 1'b1);
        chk("drop_with_clr", drop, 1'b1);
        n = busy ? 1 : 0;
        tick(1'b1, 2, 'h66, 2, 0, 1'b0);
        chk("drop_during_busy", drop, 1'b1);
        if (busy) n++;
        tick(1'b0, 0, 0, 2, 0, 1'b1);
        chk("drop_clears", drop, 1'b0);
        if (busy) n++;
        for (int k = 0; k < 20 && busy; k++) begin
            tick(1'b0, 0, 0, 2, 2, 1'b0);
            if (busy) n++;
        end
        chk("busy_no_restart", n, 8);
        tick(1'b0, 0, 0, 2, 2, 1'b0);
        chk("addr2_still_zero", rda, 8'h00);

        // Asynchronous reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) tick(1'b1, i, 'h10 + i, 0, 0, 1'b0);
        tick(1'b0, 0, 0, 7, 7, 1'b1);
        repeat (3) tick(1'b0, 0, 0, 7, 7, 1'b0);
        chk("pre_reset_rd_a", rda, 8'h17);
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_rd_a", rda, 8'h00);
        chk("async_reset_rd_b", rdb, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            tick(1'b0, 0, 0, a, a, 1'b0);
            chk($sformatf("post_reset_addr%0d", a), rda, 8'h00);
        end
        chk("post_reset_busy", busy, 1'b0);

        // Out-of-range index on a DEPTH=6 array.
        d6_we = 1'b1; d6_wa = 3'd6; d6_wd = 8'hFF; d6_ra = 3'd6;
        @(posedge clk); @(negedge clk);
        chk("d6_oob_drop", d6_drop, 1'b1);
        chk("d6_oob_read", d6_rda, 8'h00);
        d6_we = 1'b1; d6_wa = 3'd5; d6_wd = 8'h5A; d6_ra = 3'd6;
        @(posedge clk); @(negedge clk);
        chk("d6_inrange_no_drop", d6_drop, 1'b0);
        d6_we = 1'b0; d6_ra = 3'd5; d6_rb = 3'd7;
        @(posedge clk); @(negedge clk);
        chk("d6_addr5_read", d6_rda, 8'h5A);
        chk("d6_addr7_read", d6_rdb, 8'h00);
        d6_ra = 3'd6;
        @(posedge clk); @(negedge clk);
        chk("d6_addr6_after", d6_rda, 8'h00);
        chk("d6_drop_low", d6_drop, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
